// File: rtl/acc_burst.sv
// Burst accumulator: folds a stream of signed operands into one sum through a
// ripple-carry adder, then offers the result and a sticky overflow flag.

module rca_add #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s,
  output logic         ovf
);

  always_comb begin : ripple
    logic c;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
  end

  assign ovf = (a[N-1] == b[N-1]) & (s[N-1] != a[N-1]);

endmodule

module acc_burst #(
  parameter int unsigned N   = 32,
  parameter int unsigned LW  = 8,
  parameter bit          SAT = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  sum,
  output logic          ovf,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  sum_q, sum_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          ovf_q, ovf_d;

  logic [N-1:0]  add_s;
  logic          add_ovf;
  logic [N-1:0]  acc_next;
  logic          beat;
  logic          last_beat;

  localparam logic [N-1:0] MaxVal = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MinVal = {1'b1, {(N-1){1'b0}}};

  rca_add #(
    .N (N)
  ) u_add (
    .a   (acc_q),
    .b   (in_data),
    .s   (add_s),
    .ovf (add_ovf)
  );

  // Overflow means both operands share a sign, so in_data's sign picks the rail.
  assign acc_next  = (SAT && add_ovf) ? (in_data[N-1] ? MinVal : MaxVal) : add_s;
  assign beat      = (state_q == StRun) & in_valid;
  assign last_beat = beat & (rem_q == LW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (len != '0) ? StRun : StDone;
      end
      StRun: begin
        if (last_beat) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StRun);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    rem_d = rem_q;
    ovf_d = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ovf_d = 1'b0;
          if (len != '0) begin
            acc_d = '0;
            rem_d = len;
          end else begin
            sum_d = '0;
          end
        end
      end
      StRun: begin
        if (beat) begin
          acc_d = acc_next;
          ovf_d = ovf_q | add_ovf;
          rem_d = rem_q - LW'(1);
          if (last_beat) sum_d = acc_next;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      sum_q <= '0;
      rem_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
      rem_q <= rem_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum = sum_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_acc_burst.sv
// Drives a wrapping and a saturating acc_burst with identical bursts and
// checks both against an integer-arithmetic model.

module tb_acc_burst;

  localparam int N  = 32;
  localparam int LW = 8;
  localparam longint MaxV = 64'sd2147483647;
  localparam longint MinV = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic          out_ready = 1'b0;

  logic          w_in_ready, w_out_valid, w_ovf, w_busy;
  logic [N-1:0]  w_sum;
  logic          s_in_ready, s_out_valid, s_ovf, s_busy;
  logic [N-1:0]  s_sum;

  acc_burst #(.N(N), .LW(LW), .SAT(1'b0)) u_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .in_data   (in_data),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .sum       (w_sum),
    .ovf       (w_ovf),
    .busy      (w_busy)
  );

  acc_burst #(.N(N), .LW(LW), .SAT(1'b1)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_data   (in_data),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .sum       (s_sum),
    .ovf       (s_ovf),
    .busy      (s_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] ops[$];
  logic [N-1:0] m_wrap, m_sat;
  bit           m_ovw, m_ovs;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mathematical sum per beat; out-of-range means signed overflow.
  task automatic model_beat(input logic [N-1:0] x);
    longint t;
    t = longint'($signed(m_wrap)) + longint'($signed(x));
    if (t > MaxV || t < MinV) m_ovw = 1'b1;
    m_wrap = 32'(t);
    t = longint'($signed(m_sat)) + longint'($signed(x));
    if (t > MaxV) begin
      m_sat = 32'h7fff_ffff;
      m_ovs = 1'b1;
    end else if (t < MinV) begin
      m_sat = 32'h8000_0000;
      m_ovs = 1'b1;
    end else begin
      m_sat = 32'(t);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " sum"},       w_sum,       '0);
    chk({tag, " ovf"},       w_ovf,       0);
    chk({tag, " out_valid"}, w_out_valid, 0);
    chk({tag, " in_ready"},  w_in_ready,  0);
    chk({tag, " busy"},      w_busy,      0);
    chk({tag, " sat.sum"},   s_sum,       '0);
    chk({tag, " sat.busy"},  s_busy,      0);
  endtask

  task automatic chk_result(input string tag);
    chk({tag, " out_valid"},     w_out_valid, 1);
    chk({tag, " in_ready"},      w_in_ready,  0);
    chk({tag, " busy"},          w_busy,      1);
    chk({tag, " sum"},           w_sum,       m_wrap);
    chk({tag, " ovf"},           w_ovf,       m_ovw);
    chk({tag, " sat.out_valid"}, s_out_valid, 1);
    chk({tag, " sat.sum"},       s_sum,       m_sat);
    chk({tag, " sat.ovf"},       s_ovf,       m_ovs);
  endtask

  // bubbles: 0 none, 1 one idle cycle between beats, 2 random idle cycles.
  task automatic run_burst(input string tag, input int bubbles, input int hold);
    chk({tag, " idle before start"}, w_busy, 0);
    m_wrap = '0;
    m_sat  = '0;
    m_ovw  = 1'b0;
    m_ovs  = 1'b0;
    start  = 1'b1;
    len    = LW'(ops.size());
    tick();
    start  = 1'b0;
    if (ops.size() > 0) begin
      chk({tag, " run in_ready"},  w_in_ready,  1);
      chk({tag, " run out_valid"}, w_out_valid, 0);
    end
    foreach (ops[i]) begin
      if ((bubbles == 1 && i > 0) || (bubbles == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        tick();
        chk({tag, " bubble in_ready"}, w_in_ready, 1);
      end
      in_valid = 1'b1;
      in_data  = ops[i];
      model_beat(ops[i]);
      tick();
      in_valid = 1'b0;
      if (i < ops.size() - 1) chk({tag, " mid out_valid"}, w_out_valid, 0);
    end
    chk_result(tag);
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      start     = 1'($urandom);
      len       = LW'($urandom);
      in_valid  = 1'($urandom);
      in_data   = $urandom;
      tick();
      chk_result({tag, " hold"});
    end
    in_valid  = 1'b0;
    start     = 1'($urandom);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk({tag, " after hs out_valid"}, w_out_valid, 0);
    chk({tag, " after hs busy"},      w_busy,      0);
    chk({tag, " after hs sum kept"},  w_sum,       m_wrap);
    chk({tag, " after hs ovf kept"},  w_ovf,       m_ovw);
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    ops = '{32'd32, 32'd61};
    run_burst("t1", 0, 2);
    chk("t1 sum=93", w_sum, 32'd93);

    ops = '{32'd90, 32'd59, -32'sd100};
    run_burst("t2", 1, 0);
    chk("t2 sum=49", w_sum, 32'd49);

    ops = '{32'hffff_ffff, 32'd122};
    run_burst("t3a", 0, 1);
    chk("t3a sum=121", w_sum, 32'd121);

    ops = '{32'h7fff_ffff, 32'd1};
    run_burst("t3b", 0, 0);
    chk("t3b wrap sum", w_sum, 32'h8000_0000);
    chk("t3b sat sum",  s_sum, 32'h7fff_ffff);

    ops = '{32'h7fff_ffff, 32'd1, 32'hffff_ffff};
    run_burst("t4a", 0, 0);
    chk("t4a sticky ovf", w_ovf, 1);
    chk("t4a wrap sum",   w_sum, 32'h7fff_ffff);

    ops = '{32'd5};
    run_burst("t4b", 0, 0);
    chk("t4b ovf cleared", w_ovf, 0);

    ops.delete();
    run_burst("t5", 0, 5);

    start = 1'b1;
    len   = LW'(3);
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'd7;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_outputs("t6 mid-burst reset");
    ops = '{32'd7};
    run_burst("t6", 0, 0);
    chk("t6 sum=7", w_sum, 32'd7);

    for (int b = 0; b < 25; b++) begin
      int n;
      n = $urandom_range(0, 6);
      ops.delete();
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 3))
          0:       ops.push_back($urandom);
          1:       ops.push_back(32'h7fff_fff0 + 32'($urandom_range(0, 31)));
          2:       ops.push_back(32'h8000_0010 - 32'($urandom_range(0, 31)));
          default: ops.push_back(32'($signed($urandom_range(0, 200)) - 100));
        endcase
      end
      run_burst($sformatf("rnd%0d", b), 2, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
